program_loader: RTL and testbench
=================================

# program_loader

UART program-load engine for the MIPS debug unit. Once the debug command decoder has recognised the load-program command (0x07), this block consumes the byte stream from `uart_rx`. That stream is one instruction-count byte followed by that many 32-bit instructions, each sent least-significant byte first. The block assembles each instruction and writes it into instruction memory at consecutive word addresses starting at 0. While loading, it holds the pipeline off through `o_busy`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of the instruction-memory byte address.
- `MAX_INSTRUCTION`, 64: largest accepted instruction count.
- `TIMEOUT_CYCLES`, 1_000_000: idle-cycle limit between bytes while loading. 0 disables the timeout.

Ports:
- `i_clk`  in  1: the block's single clock.
- `i_rst`  in  1: synchronous, active-low reset.
- `i_start`  in  1: one-cycle pulse from the command decoder after byte 0x07.
- `i_rx_data`  in  8: received byte.
- `i_rx_valid`  in  1: one-cycle strobe; `i_rx_data` is valid in that cycle.
- `o_imem_we`  out  1: instruction-memory write enable, one cycle per word.
- `o_imem_addr`  out  ADDR_WIDTH: byte address of the write; always a multiple of 4.
- `o_imem_data`  out  32: assembled instruction.
- `o_busy`  out  1: load in progress; the CPU must not fetch or step.
- `o_done`  out  1: one-cycle pulse at the end of a load, whether it succeeded or failed.
- `o_error`  out  1: sticky error flag; cleared on the next accepted `i_start`.
- `o_count`  out  8: instruction count received for the current or most recent load.

## Operation
- Reset values: every output is 0 and the state is IDLE.
- States: IDLE → COUNT → BYTE[0..3] → (CHECK) → DONE → IDLE.
- IDLE:
  - On `i_start`: go to COUNT, clear `o_error` and the word counter, and set `o_busy`.
  - `i_rx_valid` is ignored in IDLE.
- COUNT: on `i_rx_valid`, latch `o_count` from `i_rx_data`, then:
  - count = 0 → DONE, with no writes.
  - count > `MAX_INSTRUCTION` → set `o_error`, go to DONE, with no writes.
  - otherwise → BYTE0.
- BYTE k: on `i_rx_valid`, place `i_rx_data` into bits [8k+7:8k] of the shift register.
- After BYTE3 accepts a byte:
  - Register a write: `o_imem_we`=1, `o_imem_addr`=word_index·4, `o_imem_data`=the assembled word.
  - Increment word_index.
  - If word_index then equals the count → DONE (or CHECK when the checksum feature is compiled in); otherwise → BYTE0.
- The write is registered, not a separate state. A byte arriving in the cycle `o_imem_we` is high is accepted normally as BYTE0 of the next word.
- Timeout:
  - In COUNT, BYTE or CHECK, an idle counter increments every cycle with no `i_rx_valid` and resets on each `i_rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`: set `o_error` and go to DONE. Writes already issued stand; the partial word is discarded.
- DONE: `o_done`=1 for exactly one cycle, then IDLE with `o_busy`=0.
- `i_start` while `o_busy`=1 is ignored.
- `o_imem_addr` and `o_imem_data` hold their last values when `o_imem_we`=0.

## Timing
- Byte-to-write latency: a 4th byte strobed in cycle N gives `o_imem_we`=1 in cycle N+1.
- Last word: byte in cycle N → `o_imem_we` at N+1 → `o_done` at N+1 (state DONE) → `o_busy`=0 at N+2.
- Count byte of 0 or over the limit, strobed in cycle N: `o_done` at N+1; `o_error` is visible at N+1 and remains set.
- `o_busy` rises the cycle after `i_start` and stays high through the `o_done` cycle.
- Reset (`i_rst`=0) mid-load: on the next clock edge all outputs go to 0 and the state goes to IDLE. No `o_done` is produced and no further writes occur.
- A byte and the timeout expiry in the same cycle: the byte wins and the counter resets.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - After the last word (or directly after COUNT when count = 0), the block enters CHECK and waits for one extra byte.
  - The expected byte is the XOR of the count byte and every data byte.
  - On mismatch, `o_error` is set; `o_done` pulses in either case.
  - Writes are not rolled back.
- Not defined: there is no CHECK state and no extra byte is consumed.

## Test plan
- Normal load, 2 words:
  - Stimulus: `i_start`, then bytes 02; 03 00 01 3C; 01 00 02 3C.
  - Required: a write to addr 0 with data 0x3C010003, a write to addr 4 with data 0x3C020001, `o_done` in the cycle after the final byte's strobe, `o_error`=0, `o_count`=2.
- Zero count:
  - Stimulus: `i_start`, byte 00.
  - Required: no `o_imem_we`, `o_done` one cycle after the strobe, `o_error`=0. With the checksum feature compiled in, send byte 00 afterwards as the checksum.
- Over-limit count with `MAX_INSTRUCTION`=64:
  - Stimulus: count byte 65 (0x41).
  - Required: `o_error`=1, `o_done` pulse, no writes. Then a new `i_start` clears `o_error`.
- Timeout with `TIMEOUT_CYCLES`=1000:
  - Stimulus: count 2, five data bytes, then silence.
  - Required: exactly one write (addr 0); `o_error`=1 and `o_done` 1000 cycles after the 5th byte.
- Reset mid-load:
  - Stimulus: count 3, one word, then `i_rst`=0 for one cycle.
  - Required: all outputs 0. A later `i_start` load of 1 word writes addr 0.
- Checksum, with `PROGRAM_LOADER_CHECKSUM_EN`:
  - Stimulus: count 01, word 03 00 01 3C, checksum 0x3F.
  - Required: `o_error`=0.
  - Repeating with checksum 0x00 gives `o_error`=1 and the write still occurs.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART program-load engine writing instructions into instruction memory
//
// Purpose: after the debug decoder sees the load-program command, consume a
// count byte followed by count 32-bit instructions (LSB first) and write them
// to consecutive word addresses starting at 0, holding the CPU off via o_busy.
//
// Optional feature: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// (count byte XOR every data byte) verified in a CHECK state.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-low reset
//   i_start             one-cycle load request (ignored while busy)
//   i_rx_data/i_rx_valid received UART byte and its strobe
//   o_imem_we/addr/data registered instruction-memory write
//   o_busy              load in progress (through the o_done cycle)
//   o_done              one-cycle end-of-load pulse, success or failure
//   o_error             sticky error, cleared by the next accepted i_start
//   o_count             instruction count of the current or last load
module program_loader #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_INSTRUCTION = 64,
    parameter int TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [7:0]            o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_BYTE0,
        S_BYTE1,
        S_BYTE2,
        S_BYTE3,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state;
    logic [23:0] shreg;
    logic [7:0]  word_idx;
    logic [31:0] idle_cnt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic       waiting;
    logic       timeout_hit;
    logic [7:0] next_idx;

    // idle_cnt holds the number of cycles since the last accepted byte
    // (the byte cycle itself counts as 1), so expiry lands o_done exactly
    // TIMEOUT_CYCLES cycles after the last strobe.
    always_comb begin
        waiting     = (state == S_COUNT) || (state == S_BYTE0) || (state == S_BYTE1) ||
                      (state == S_BYTE2) || (state == S_BYTE3) || (state == S_CHECK);
        timeout_hit = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            timeout_hit = waiting && !i_rx_valid &&
                          (idle_cnt >= 32'(TIMEOUT_CYCLES - 1));
        end
        next_idx = word_idx + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            word_idx    <= '0;
            idle_cnt    <= '0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_count     <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            o_imem_we <= 1'b0;
            o_done    <= 1'b0;

            if (waiting) begin
                idle_cnt <= i_rx_valid ? 32'd1 : idle_cnt + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state    <= S_COUNT;
                        o_error  <= 1'b0;
                        word_idx <= '0;
                        o_busy   <= 1'b1;
                        idle_cnt <= 32'd1;
                    end
                end

                S_COUNT: begin
                    if (i_rx_valid) begin
                        o_count <= i_rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum    <= i_rx_data;
`endif
                        if (int'(i_rx_data) > MAX_INSTRUCTION) begin
                            o_error <= 1'b1;
                            o_done  <= 1'b1;
                            state   <= S_DONE;
                        end else if (i_rx_data == 8'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state  <= S_CHECK;
`else
                            o_done <= 1'b1;
                            state  <= S_DONE;
`endif
                        end else begin
                            state <= S_BYTE0;
                        end
                    end
                end

                S_BYTE0, S_BYTE1, S_BYTE2: begin
                    if (i_rx_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum <= csum ^ i_rx_data;
`endif
                        case (state)
                            S_BYTE0: begin shreg[7:0]   <= i_rx_data; state <= S_BYTE1; end
                            S_BYTE1: begin shreg[15:8]  <= i_rx_data; state <= S_BYTE2; end
                            default: begin shreg[23:16] <= i_rx_data; state <= S_BYTE3; end
                        endcase
                    end
                end

                S_BYTE3: begin
                    if (i_rx_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum <= csum ^ i_rx_data;
`endif
                        o_imem_we   <= 1'b1;
                        o_imem_addr <= ADDR_WIDTH'({word_idx, 2'b00});
                        o_imem_data <= {i_rx_data, shreg};
                        word_idx    <= next_idx;
                        if (next_idx == o_count) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state  <= S_CHECK;
`else
                            o_done <= 1'b1;
                            state  <= S_DONE;
`endif
                        end else begin
                            state <= S_BYTE0;
                        end
                    end
                end

                S_CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (i_rx_valid) begin
                        if (i_rx_data != csum) begin
                            o_error <= 1'b1;
                        end
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end
`else
                    state <= S_IDLE;
`endif
                end

                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase

            // Expiry only fires on a cycle without a byte, so a byte always wins;
            // any partial word in shreg is simply abandoned.
            if (timeout_hit) begin
                o_error <= 1'b1;
                o_done  <= 1'b1;
                state   <= S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [7:0]  o_count;

    program_loader #(
        .ADDR_WIDTH(32),
        .MAX_INSTRUCTION(64),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid),
        .o_imem_we(o_imem_we),
        .o_imem_addr(o_imem_addr),
        .o_imem_data(o_imem_data),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error),
        .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          wr_count = 0;
    int          done_count = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_imem_we) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= o_imem_addr;
            last_wr_data <= o_imem_data;
        end
        if (o_done) done_count <= done_count + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All drivers start #1 after a rising edge and return #1 after the next one.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        last_cyc   = cyc;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_vec({tag, "_we"},    32'(o_imem_we), 32'd0);
        check_vec({tag, "_addr"},  o_imem_addr,    32'd0);
        check_vec({tag, "_data"},  o_imem_data,    32'd0);
        check_vec({tag, "_busy"},  32'(o_busy),    32'd0);
        check_vec({tag, "_done"},  32'(o_done),    32'd0);
        check_vec({tag, "_error"}, 32'(o_error),   32'd0);
        check_vec({tag, "_count"}, 32'(o_count),   32'd0);
    endtask

    int  w0;
    int  d0;
    int  dcyc;
    logic seen;

    initial begin
        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        i_rst = 1'b1;
        tick();

        // Normal 2-word load; second word starts in the write cycle of the first
        w0 = wr_count;
        start_pulse();
        check_vec("busy_after_start", 32'(o_busy), 32'd1);
        put(8'h02);
        put(8'h03); put(8'h00); put(8'h01); put(8'h3C);
        check_vec("w0_we",   32'(o_imem_we), 32'd1);
        check_vec("w0_addr", o_imem_addr,    32'd0);
        check_vec("w0_data", o_imem_data,    32'h3C010003);
        check_vec("w0_done", 32'(o_done),    32'd0);
        put(8'h01); put(8'h00); put(8'h02); put(8'h3C);
        check_vec("w1_we",   32'(o_imem_we), 32'd1);
        check_vec("w1_addr", o_imem_addr,    32'd4);
        check_vec("w1_data", o_imem_data,    32'h3C020001);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        put(8'h03);
`endif
        check_vec("norm_done",  32'(o_done),  32'd1);
        check_vec("norm_busy1", 32'(o_busy),  32'd1);
        tick();
        check_vec("norm_busy0", 32'(o_busy),  32'd0);
        check_vec("norm_done0", 32'(o_done),  32'd0);
        check_vec("norm_error", 32'(o_error), 32'd0);
        check_vec("norm_count", 32'(o_count), 32'd2);
        check_vec("norm_hold_addr", o_imem_addr, 32'd4);
        check_vec("norm_hold_data", o_imem_data, 32'h3C020001);
        check_vec("norm_writes", 32'(wr_count - w0), 32'd2);

        // Zero count
        w0 = wr_count;
        d0 = done_count;
        start_pulse();
        put(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        put(8'h00);
`endif
        check_vec("zero_done",  32'(o_done),  32'd1);
        check_vec("zero_error", 32'(o_error), 32'd0);
        tick();
        check_vec("zero_busy",   32'(o_busy), 32'd0);
        check_vec("zero_writes", 32'(wr_count - w0), 32'd0);
        check_vec("zero_dones",  32'(done_count - d0), 32'd1);

        // Over-limit count 65: error, no writes, sticky until next start
        w0 = wr_count;
        start_pulse();
        put(8'h41);
        check_vec("over_done",  32'(o_done),  32'd1);
        check_vec("over_error", 32'(o_error), 32'd1);
        tick();
        check_vec("over_sticky", 32'(o_error), 32'd1);
        check_vec("over_busy",   32'(o_busy),  32'd0);
        check_vec("over_count",  32'(o_count), 32'h41);
        repeat (3) tick();
        check_vec("over_writes", 32'(wr_count - w0), 32'd0);
        start_pulse();
        check_vec("restart_clr_error", 32'(o_error), 32'd0);
        put(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        put(8'h00);
`endif
        tick();

        // Count 64 is the largest accepted count: must not error
        start_pulse();
        put(8'h40);
        tick();
        check_vec("max_accept_error", 32'(o_error), 32'd0);
        check_vec("max_accept_busy",  32'(o_busy),  32'd1);
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();

        // Timeout: count 2, five data bytes, silence
        w0 = wr_count;
        start_pulse();
        put(8'h02);
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        put(8'h55);
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        check_vec("to_seen",    32'(seen), 32'd1);
        check_vec("to_latency", 32'(dcyc - last_cyc), 32'd1000);
        check_vec("to_error",   32'(o_error), 32'd1);
        check_vec("to_writes",  32'(wr_count - w0), 32'd1);
        check_vec("to_wr_addr", last_wr_addr, 32'd0);
        check_vec("to_wr_data", last_wr_data, 32'h44332211);
        tick();

        // Start while busy is ignored
        w0 = wr_count;
        start_pulse();
        put(8'h01);
        start_pulse();
        put(8'hEF); put(8'hBE); put(8'hAD); put(8'hDE);
        check_vec("ign_we",   32'(o_imem_we), 32'd1);
        check_vec("ign_data", o_imem_data,    32'hDEADBEEF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        put(8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
        check_vec("ign_done",  32'(o_done),  32'd1);
        check_vec("ign_error", 32'(o_error), 32'd0);
        tick();

        // Reset mid-load
        d0 = done_count;
        start_pulse();
        put(8'h03);
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        check_all_zero("midrst");
        w0 = wr_count;
        repeat (4) tick();
        check_vec("midrst_no_done",   32'(done_count - d0), 32'd0);
        check_vec("midrst_no_writes", 32'(wr_count - w0),   32'd0);
        start_pulse();
        put(8'h01);
        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
        check_vec("after_rst_addr", o_imem_addr, 32'd0);
        check_vec("after_rst_data", o_imem_data, 32'hDDCCBBAA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        put(8'h01);
`endif
        check_vec("after_rst_done", 32'(o_done), 32'd1);
        tick();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum good and bad
        start_pulse();
        put(8'h01);
        put(8'h03); put(8'h00); put(8'h01); put(8'h3C);
        put(8'h3F);
        check_vec("cs_good_done",  32'(o_done),  32'd1);
        check_vec("cs_good_error", 32'(o_error), 32'd0);
        tick();
        w0 = wr_count;
        start_pulse();
        put(8'h01);
        put(8'h03); put(8'h00); put(8'h01); put(8'h3C);
        put(8'h00);
        check_vec("cs_bad_done",   32'(o_done),  32'd1);
        check_vec("cs_bad_error",  32'(o_error), 32'd1);
        tick();
        check_vec("cs_bad_writes", 32'(wr_count - w0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
